// File: rtl/msrv32_bus_pkg.sv
// Shared AHB-lite transfer encodings and arbiter FSM states for the msrv32 bus arbiter.
package msrv32_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IDATA = 2'b01,
        ST_DDATA = 2'b10
    } bus_state_e;

endpackage

// File: rtl/msrv32_arb_priority.sv
// Winner selection between fetch and data requesters, with a starvation counter
// that forces a fetch grant after STARVE_MAX consecutive data grants.
module msrv32_arb_priority
    import msrv32_bus_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic i_win,
    output logic d_win
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          starved;

    always_comb begin
        starved  = (starve_q == STARVE_LIM);
        i_win    = arb_en && i_req && (!d_req || starved);
        d_win    = arb_en && d_req && !i_win;
        starve_d = starve_q;
        if (!i_req || i_win) begin
            starve_d = '0;
        end else if (d_win && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/msrv32_bus_arbiter.sv
// Two-master (fetch/data) to single AHB-lite master arbiter with pipelined
// address/data phases and starvation protection for instruction fetch.
module msrv32_bus_arbiter
    import msrv32_bus_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_gnt_out,
    output logic        i_valid_out,
    output logic        i_err_out,
    output logic [31:0] i_rdata_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_mask_in,
    output logic        d_gnt_out,
    output logic        d_valid_out,
    output logic        d_err_out,
    output logic [31:0] d_rdata_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [3:0]  hmask_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    bus_state_e  state_q;
    bus_state_e  state_d;
    logic [31:0] hwdata_q;
    logic [31:0] hwdata_d;
    logic        arb_en;
    logic        phase_done;
    logic        i_win;
    logic        d_win;

    // Reset gates both arbitration and completion so every output reads 0 while asserted.
    assign arb_en     = !ms_riscv32_mp_rst_in && ((state_q == ST_IDLE) || hready_in);
    assign phase_done = !ms_riscv32_mp_rst_in && (state_q != ST_IDLE) && hready_in;

    msrv32_arb_priority #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb_priority (
        .clk    (ms_riscv32_mp_clk_in),
        .rst    (ms_riscv32_mp_rst_in),
        .arb_en (arb_en),
        .i_req  (i_req_in),
        .d_req  (d_req_in),
        .i_win  (i_win),
        .d_win  (d_win)
    );

    always_comb begin
        htrans_out  = HTRANS_IDLE;
        haddr_out   = '0;
        hwrite_out  = 1'b0;
        hmask_out   = '0;
        i_gnt_out   = i_win;
        d_gnt_out   = d_win;
        i_valid_out = 1'b0;
        i_err_out   = 1'b0;
        i_rdata_out = '0;
        d_valid_out = 1'b0;
        d_err_out   = 1'b0;
        d_rdata_out = '0;
        hwdata_out  = (!ms_riscv32_mp_rst_in && (state_q == ST_DDATA)) ? hwdata_q : '0;

        if (i_win) begin
            htrans_out = HTRANS_NONSEQ;
            haddr_out  = i_addr_in;
            hmask_out  = 4'hF;
        end else if (d_win) begin
            htrans_out = HTRANS_NONSEQ;
            haddr_out  = d_addr_in;
            hwrite_out = d_we_in;
            hmask_out  = d_mask_in;
        end

        if (phase_done && (state_q == ST_IDATA)) begin
            i_err_out   = hresp_in;
            i_valid_out = !hresp_in;
            i_rdata_out = hresp_in ? '0 : hrdata_in;
        end
        if (phase_done && (state_q == ST_DDATA)) begin
            d_err_out   = hresp_in;
            d_valid_out = !hresp_in;
            d_rdata_out = hresp_in ? '0 : hrdata_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        hwdata_d = hwdata_q;
        if (i_win) begin
            state_d  = ST_IDATA;
            hwdata_d = '0;
        end else if (d_win) begin
            state_d  = ST_DDATA;
            hwdata_d = d_we_in ? d_wdata_in : '0;
        end else if (phase_done) begin
            state_d  = ST_IDLE;
            hwdata_d = '0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= ST_IDLE;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hwdata_q <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_msrv32_bus_arbiter.sv
// Scenario bench for msrv32_bus_arbiter: grants checked as driven, completions
// checked against a queue of expected responses.
module tb_msrv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, hready, hresp;
    logic [31:0] i_addr, d_addr, d_wdata, hrdata;
    logic [3:0]  d_mask;
    logic        i_gnt, i_valid, i_err, d_gnt, d_valid, d_err, hwrite;
    logic [31:0] i_rdata, d_rdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [3:0]  hmask;

    typedef struct {
        bit          fetch;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    msrv32_bus_arbiter #(.STARVE_MAX(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .i_req_in    (i_req),
        .i_addr_in   (i_addr),
        .i_gnt_out   (i_gnt),
        .i_valid_out (i_valid),
        .i_err_out   (i_err),
        .i_rdata_out (i_rdata),
        .d_req_in    (d_req),
        .d_we_in     (d_we),
        .d_addr_in   (d_addr),
        .d_wdata_in  (d_wdata),
        .d_mask_in   (d_mask),
        .d_gnt_out   (d_gnt),
        .d_valid_out (d_valid),
        .d_err_out   (d_err),
        .d_rdata_out (d_rdata),
        .haddr_out   (haddr),
        .htrans_out  (htrans),
        .hwrite_out  (hwrite),
        .hmask_out   (hmask),
        .hwdata_out  (hwdata),
        .hrdata_in   (hrdata),
        .hready_in   (hready),
        .hresp_in    (hresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; hready = 1'b1; hresp = 1'b0;
        i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF; d_mask = 4'hF; hrdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({i_gnt, i_valid, i_err, i_rdata, d_gnt, d_valid, d_err, d_rdata,
                 haddr, htrans, hwrite, hmask, hwdata} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: gnt=%b%b htrans=%b haddr=%h hmask=%h, required all zero",
                         i_gnt, d_gnt, htrans, haddr, hmask);
            end
            step();
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; hrdata = '0;
    endtask

    task automatic test_fetch();
        exp_t e;
        i_req = 1'b1; i_addr = 32'h100; hrdata = 32'h13; hready = 1'b1;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, htrans, haddr, hwrite, hmask} !== {1'b1, 1'b0, 2'b10, 32'h100, 1'b0, 4'hF}) begin
            bad++;
            $display("FAIL fetch_grant: gnt=%b%b htrans=%b haddr=%h hwrite=%b hmask=%h, required 10 10 00000100 0 f",
                     i_gnt, d_gnt, htrans, haddr, hwrite, hmask);
        end
        sb.push_back('{1'b1, 1'b0, 32'h13});
        step();
        i_req = 1'b0;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL fetch_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                bad++;
                $display("FAIL fetch_cmpl: flags=%b%b%b%b i_rdata=%h d_rdata=%h, required fetch=%0b err=%0b rdata=%h",
                         i_valid, i_err, d_valid, d_err, i_rdata, d_rdata, e.fetch, e.err, e.rdata);
            end
        end
        total++;
        if ({i_gnt, d_gnt, htrans, haddr} !== '0) begin
            bad++;
            $display("FAIL fetch_idle_after: gnt=%b%b htrans=%b haddr=%h, required 00 00 0", i_gnt, d_gnt, htrans, haddr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_mask = 4'h3;
        i_req = 1'b1; i_addr = 32'h104; hrdata = 32'h0;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, htrans, haddr, hwrite, hmask, hwdata} !== {1'b0, 1'b1, 2'b10, 32'h2000, 1'b1, 4'h3, 32'h0}) begin
            bad++;
            $display("FAIL b2b_data_grant: gnt=%b%b haddr=%h hwrite=%b hmask=%h hwdata=%h, required 01 00002000 1 3 0",
                     i_gnt, d_gnt, haddr, hwrite, hmask, hwdata);
        end
        sb.push_back('{1'b0, 1'b0, 32'h55});
        step();
        d_req = 1'b0; d_wdata = 32'h0; hrdata = 32'h55;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL b2b_data_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                bad++;
                $display("FAIL b2b_data_cmpl: flags=%b%b%b%b i_rdata=%h d_rdata=%h, required fetch=%0b err=%0b rdata=%h",
                         i_valid, i_err, d_valid, d_err, i_rdata, d_rdata, e.fetch, e.err, e.rdata);
            end
        end
        total++;
        if ({hwdata, i_gnt, d_gnt, htrans, haddr, hwrite, hmask} !== {32'hDEAD_BEEF, 1'b1, 1'b0, 2'b10, 32'h104, 1'b0, 4'hF}) begin
            bad++;
            $display("FAIL b2b_fetch_grant: hwdata=%h gnt=%b%b haddr=%h hwrite=%b hmask=%h, required deadbeef 10 00000104 0 f",
                     hwdata, i_gnt, d_gnt, haddr, hwrite, hmask);
        end
        sb.push_back('{1'b1, 1'b0, 32'h66});
        step();
        i_req = 1'b0; hrdata = 32'h66;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL b2b_fetch_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0) ||
                hwdata !== 32'h0) begin
                bad++;
                $display("FAIL b2b_fetch_cmpl: flags=%b%b%b%b i_rdata=%h hwdata=%h, required fetch=%0b err=%0b rdata=%h hwdata=0",
                         i_valid, i_err, d_valid, d_err, i_rdata, hwdata, e.fetch, e.err, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_starvation();
        exp_t e;
        bit   exp_fetch;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_mask = 4'hF;
        i_req = 1'b1; i_addr = 32'h200;
        for (int k = 0; k < 15; k++) begin
            hrdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            if (k > 0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL starve_cmpl: no expected entry at k=%0d", k);
                end else begin
                    e = sb.pop_front();
                    if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                        i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                        bad++;
                        $display("FAIL starve_cmpl k=%0d: flags=%b%b%b%b i_rdata=%h d_rdata=%h, required fetch=%0b rdata=%h",
                                 k, i_valid, i_err, d_valid, d_err, i_rdata, d_rdata, e.fetch, e.rdata);
                    end
                end
            end
            exp_fetch = ((k % 5) == 4);
            total++;
            if ({i_gnt, d_gnt} !== {exp_fetch, !exp_fetch}) begin
                bad++;
                $display("FAIL starve_grant k=%0d: gnt=%b%b, required %b%b", k, i_gnt, d_gnt, exp_fetch, !exp_fetch);
            end
            sb.push_back('{exp_fetch, 1'b0, 32'hA000_0000 + 32'(k + 1)});
            step();
        end
        i_req = 1'b0; d_req = 1'b0; hrdata = 32'hA000_000F;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL starve_drain: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                bad++;
                $display("FAIL starve_drain: flags=%b%b%b%b d_rdata=%h, required fetch=%0b rdata=%h",
                         i_valid, i_err, d_valid, d_err, d_rdata, e.fetch, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_wait_states();
        exp_t e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h1234_5678; d_mask = 4'hF;
        @(negedge clk);
        total++;
        if ({d_gnt, hwrite, haddr} !== {1'b1, 1'b1, 32'h3000}) begin
            bad++;
            $display("FAIL wait_grant: d_gnt=%b hwrite=%b haddr=%h, required 1 1 00003000", d_gnt, hwrite, haddr);
        end
        sb.push_back('{1'b0, 1'b0, 32'h77});
        step();
        d_req = 1'b0; d_wdata = 32'h0; hready = 1'b0; i_req = 1'b1; i_addr = 32'h300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({i_gnt, d_gnt, htrans, d_valid, d_err, hwdata} !== {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h1234_5678}) begin
                bad++;
                $display("FAIL wait_hold c=%0d: gnt=%b%b htrans=%b d_valid=%b hwdata=%h, required 00 00 0 12345678",
                         c, i_gnt, d_gnt, htrans, d_valid, hwdata);
            end
            step();
        end
        hready = 1'b1; hrdata = 32'h77;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL wait_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || d_rdata !== ((!e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                bad++;
                $display("FAIL wait_cmpl: flags=%b%b%b%b d_rdata=%h, required fetch=%0b rdata=%h",
                         i_valid, i_err, d_valid, d_err, d_rdata, e.fetch, e.rdata);
            end
        end
        total++;
        if ({i_gnt, haddr, hwdata} !== {1'b1, 32'h300, 32'h1234_5678}) begin
            bad++;
            $display("FAIL wait_pipelined_grant: i_gnt=%b haddr=%h hwdata=%h, required 1 00000300 12345678", i_gnt, haddr, hwdata);
        end
        sb.push_back('{1'b1, 1'b0, 32'h88});
        step();
        i_req = 1'b0; hrdata = 32'h88;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL wait_fetch_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0) || hwdata !== 32'h0) begin
                bad++;
                $display("FAIL wait_fetch_cmpl: flags=%b%b%b%b i_rdata=%h hwdata=%h, required fetch=%0b rdata=%h hwdata=0",
                         i_valid, i_err, d_valid, d_err, i_rdata, hwdata, e.fetch, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_error();
        exp_t e;
        i_req = 1'b1; i_addr = 32'h400; hrdata = 32'h99;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, haddr} !== {1'b1, 1'b0, 32'h400}) begin
            bad++;
            $display("FAIL err_grant: gnt=%b%b haddr=%h, required 10 00000400", i_gnt, d_gnt, haddr);
        end
        sb.push_back('{1'b1, 1'b1, 32'h0});
        step();
        i_req = 1'b0; hresp = 1'b1;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL err_cmpl: no expected entry");
        end else begin
            e = sb.pop_front();
            if ({i_valid, i_err, d_valid, d_err} !== {e.fetch && !e.err, e.fetch && e.err, !e.fetch && !e.err, !e.fetch && e.err} ||
                i_rdata !== ((e.fetch && !e.err) ? e.rdata : 32'h0)) begin
                bad++;
                $display("FAIL err_cmpl: flags=%b%b%b%b i_rdata=%h, required i_err=1 i_valid=0 rdata=0",
                         i_valid, i_err, d_valid, d_err, i_rdata);
            end
        end
        step();
        hresp = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFE_F00D; hrdata = 32'hAA;
        @(negedge clk);
        total++;
        if ({d_gnt, haddr} !== {1'b1, 32'h500}) begin
            bad++;
            $display("FAIL rstmid_grant: d_gnt=%b haddr=%h, required 1 00000500", d_gnt, haddr);
        end
        step();
        d_req = 1'b0; hready = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++;
        if ({i_gnt, i_valid, i_err, i_rdata, d_gnt, d_valid, d_err, d_rdata,
             haddr, htrans, hwrite, hmask, hwdata} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: d_valid=%b htrans=%b hwdata=%h, required all zero", d_valid, htrans, hwdata);
        end
        step();
        rst = 1'b0; hready = 1'b1;
        @(negedge clk);
        total++;
        if ({d_valid, d_err, d_rdata, htrans, hwdata, i_gnt, d_gnt} !== '0) begin
            bad++;
            $display("FAIL rstmid_abandon: d_valid=%b d_err=%b htrans=%b hwdata=%h, required all zero",
                     d_valid, d_err, htrans, hwdata);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_starvation();
        test_wait_states();
        test_error();
        test_reset_mid_phase();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
